// File: rtl/btn_input_ctrl_pkg.sv
// Shared encodings for the push-button front end: direction codes, debounce
// states and button bit positions within btn_held/btn_press.
package btn_input_ctrl_pkg;

  typedef enum logic [1:0] {
    DEB_IDLE            = 2'd0,
    DEB_CONFIRM_PRESS   = 2'd1,
    DEB_HELD            = 2'd2,
    DEB_CONFIRM_RELEASE = 2'd3
  } deb_state_e;

  // One-hot codes shared with the game-logic block.
  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  localparam int BTN_R   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_U   = 3;
  localparam int BTN_C   = 4;
  localparam int BTN_NUM = 5;

  // Simultaneous direction presses resolve U > D > L > R.
  function automatic logic [3:0] dir_encode(input logic [3:0] dir_press);
    if (dir_press[BTN_U])      return DIR_UP;
    else if (dir_press[BTN_D]) return DIR_DOWN;
    else if (dir_press[BTN_L]) return DIR_LEFT;
    else if (dir_press[BTN_R]) return DIR_RIGHT;
    else                       return DIR_NONE;
  endfunction

endpackage

// File: rtl/btn_input_ctrl_debounce.sv
// One button: 2-FF synchroniser, four-state debounce FSM with a shared
// confirm counter, and a single-cycle press pulse on accepted presses.
module btn_debounce
  import btn_input_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic held,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  deb_state_e       state;
  logic [CNT_W-1:0] cnt;

  // NOTE: every register here uses non-blocking assignment so the FSM sees the
  // synchroniser output from before the edge, giving a fixed two-cycle latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync  <= 2'b00;
      state <= DEB_IDLE;
      cnt   <= '0;
      held  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      case (state)
        DEB_IDLE: begin
          if (sync[1]) begin
            state <= DEB_CONFIRM_PRESS;
            cnt   <= '0;
          end
        end
        DEB_CONFIRM_PRESS: begin
          if (!sync[1]) begin
            state <= DEB_IDLE;
          end else if (cnt == CNT_MAX) begin
            state <= DEB_HELD;
            held  <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEB_HELD: begin
          if (!sync[1]) begin
            state <= DEB_CONFIRM_RELEASE;
            cnt   <= '0;
          end
        end
        DEB_CONFIRM_RELEASE: begin
          // Counter saturates at CNT_MAX by construction, so no wrap case.
          if (sync[1]) begin
            state <= DEB_HELD;
          end else if (cnt == CNT_MAX) begin
            state <= DEB_IDLE;
            held  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DEB_IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_input_ctrl.sv
// Button front end: five debouncers, priority direction latch with valid/ack
// handshake, and an optional centre-button pause toggle (macro BTN_PAUSE_EN).
module btn_input_ctrl
  import btn_input_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  input  logic       dir_ack,
  output logic [3:0] dir_req,
  output logic       dir_valid,
  output logic [4:0] btn_held,
  output logic [4:0] btn_press,
  output logic       paused
);

  logic [BTN_NUM-1:0] btn_raw;
  logic               dir_load;
  logic [3:0]         dir_next;

  assign btn_raw = {btn_c, btn_u, btn_d, btn_l, btn_r};

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[i]),
      .held  (btn_held[i]),
      .press (btn_press[i])
    );
  end

  assign dir_next = dir_encode(btn_press[BTN_U:BTN_R]);
  assign dir_load = (|btn_press[BTN_U:BTN_R]) && !paused;

  // A press in the same cycle as dir_ack wins, so ack is only the else branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_req   <= DIR_NONE;
      dir_valid <= 1'b0;
    end else if (dir_load) begin
      dir_req   <= dir_next;
      dir_valid <= 1'b1;
    end else if (dir_ack) begin
      dir_valid <= 1'b0;
    end
  end

`ifdef BTN_PAUSE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      paused <= 1'b0;
    end else if (btn_press[BTN_C]) begin
      paused <= ~paused;
    end
  end
`else
  assign paused = 1'b0;
`endif

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed bench for btn_input_ctrl with DEB_CYCLES=4; edge numbers in the
// tasks count from the first rising edge after the stimulus change.
module tb_btn_input_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
  logic       dir_ack = 1'b0;
  logic [3:0] dir_req;
  logic       dir_valid;
  logic [4:0] btn_held;
  logic [4:0] btn_press;
  logic       paused;

  int n_cmp = 0;
  int n_err = 0;

  btn_input_ctrl #(
    .DEB_CYCLES (4),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_c     (btn_c),
    .dir_ack   (dir_ack),
    .dir_req   (dir_req),
    .dir_valid (dir_valid),
    .btn_held  (btn_held),
    .btn_press (btn_press),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    {btn_c, btn_u, btn_d, btn_l, btn_r} = 5'b0;
    dir_ack = 1'b0;
    repeat (12) tick();
  endtask

  task automatic ack_pulse();
    dir_ack = 1'b1;
    tick();
    dir_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_cmp++; if (dir_req !== 4'b0000) begin n_err++; $display("FAIL reset_dir_req: got %b want 0000", dir_req); end
    n_cmp++; if (dir_valid !== 1'b0) begin n_err++; $display("FAIL reset_dir_valid: got %b want 0", dir_valid); end
    n_cmp++; if (btn_held !== 5'b0) begin n_err++; $display("FAIL reset_held: got %b want 00000", btn_held); end
    n_cmp++; if (btn_press !== 5'b0) begin n_err++; $display("FAIL reset_press: got %b want 00000", btn_press); end
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL reset_paused: got %b want 0", paused); end
    rst = 1'b1;
  endtask

  task automatic test_clean_press();
    logic [4:0] exp5;
    btn_u = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp5 = (e == 6) ? 5'b01000 : 5'b00000;
      n_cmp++; if (btn_press !== exp5) begin n_err++; $display("FAIL clean_press@%0d: got %b want %b", e, btn_press, exp5); end
      exp5 = (e >= 6) ? 5'b01000 : 5'b00000;
      n_cmp++; if (btn_held !== exp5) begin n_err++; $display("FAIL clean_held@%0d: got %b want %b", e, btn_held, exp5); end
      n_cmp++; if (dir_valid !== (e == 7)) begin n_err++; $display("FAIL clean_valid@%0d: got %b want %b", e, dir_valid, (e == 7)); end
    end
    n_cmp++; if (dir_req !== 4'b0010) begin n_err++; $display("FAIL clean_dir_req: got %b want 0010", dir_req); end
    for (int e = 0; e < 10; e++) begin
      tick();
      n_cmp++; if (btn_press !== 5'b0) begin n_err++; $display("FAIL hold_no_repeat@%0d: got %b want 00000", e, btn_press); end
    end
    btn_u = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      exp5 = (e < 6) ? 5'b01000 : 5'b00000;
      n_cmp++; if (btn_held !== exp5) begin n_err++; $display("FAIL release_held@%0d: got %b want %b", e, btn_held, exp5); end
      n_cmp++; if (btn_press !== 5'b0) begin n_err++; $display("FAIL release_press@%0d: got %b want 00000", e, btn_press); end
    end
    n_cmp++; if (dir_valid !== 1'b1) begin n_err++; $display("FAIL release_valid: got %b want 1", dir_valid); end
    ack_pulse();
    n_cmp++; if (dir_valid !== 1'b0) begin n_err++; $display("FAIL ack_valid: got %b want 0", dir_valid); end
    n_cmp++; if (dir_req !== 4'b0010) begin n_err++; $display("FAIL ack_dir_req: got %b want 0010", dir_req); end
    settle();
  endtask

  task automatic test_bounce();
    int n_press;
    int first_edge;
    n_press = 0;
    first_edge = -1;
    for (int e = 0; e <= 14; e++) begin
      btn_r = (e == 2) ? 1'b0 : 1'b1;
      tick();
      if (btn_press[0]) begin
        n_press++;
        if (first_edge < 0) first_edge = e;
      end
      n_cmp++; if (dir_valid !== (e >= 10)) begin n_err++; $display("FAIL bounce_valid@%0d: got %b want %b", e, dir_valid, (e >= 10)); end
    end
    n_cmp++; if (n_press !== 1) begin n_err++; $display("FAIL bounce_count: got %0d want 1", n_press); end
    n_cmp++; if (first_edge !== 9) begin n_err++; $display("FAIL bounce_edge: got %0d want 9", first_edge); end
    n_cmp++; if (dir_req !== 4'b0001) begin n_err++; $display("FAIL bounce_dir_req: got %b want 0001", dir_req); end
    settle();
  endtask

  task automatic test_simultaneous();
    btn_l = 1'b1;
    btn_d = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 6) begin
        n_cmp++; if (btn_press !== 5'b00110) begin n_err++; $display("FAIL simul_press: got %b want 00110", btn_press); end
      end
    end
    n_cmp++; if (dir_req !== 4'b0100) begin n_err++; $display("FAIL simul_dir_req: got %b want 0100", dir_req); end
    n_cmp++; if (dir_valid !== 1'b1) begin n_err++; $display("FAIL simul_valid: got %b want 1", dir_valid); end
    settle();
  endtask

  task automatic test_ack_collision();
    btn_l = 1'b1;
    repeat (8) tick();
    n_cmp++; if (dir_req !== 4'b1000) begin n_err++; $display("FAIL coll_left_req: got %b want 1000", dir_req); end
    btn_r = 1'b1;
    repeat (7) tick();
    n_cmp++; if (btn_press !== 5'b00001) begin n_err++; $display("FAIL coll_right_press: got %b want 00001", btn_press); end
    ack_pulse();
    n_cmp++; if (dir_req !== 4'b0001) begin n_err++; $display("FAIL coll_dir_req: got %b want 0001", dir_req); end
    n_cmp++; if (dir_valid !== 1'b1) begin n_err++; $display("FAIL coll_valid: got %b want 1", dir_valid); end
    ack_pulse();
    n_cmp++; if (dir_valid !== 1'b0) begin n_err++; $display("FAIL lone_ack_valid: got %b want 0", dir_valid); end
    n_cmp++; if (dir_req !== 4'b0001) begin n_err++; $display("FAIL lone_ack_req: got %b want 0001", dir_req); end
    ack_pulse();
    n_cmp++; if (dir_valid !== 1'b0) begin n_err++; $display("FAIL idle_ack_valid: got %b want 0", dir_valid); end
    settle();
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp5;
    btn_d = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (dir_req !== 4'b0000) begin n_err++; $display("FAIL midrst_dir_req: got %b want 0000", dir_req); end
    n_cmp++; if (dir_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", dir_valid); end
    n_cmp++; if ({btn_held, btn_press} !== 10'b0) begin n_err++; $display("FAIL midrst_btn: got %b want 0", {btn_held, btn_press}); end
    rst = 1'b1;
    for (int j = 0; j <= 7; j++) begin
      tick();
      exp5 = (j == 6) ? 5'b00100 : 5'b00000;
      n_cmp++; if (btn_press !== exp5) begin n_err++; $display("FAIL midrst_press@%0d: got %b want %b", j, btn_press, exp5); end
      exp5 = (j >= 6) ? 5'b00100 : 5'b00000;
      n_cmp++; if (btn_held !== exp5) begin n_err++; $display("FAIL midrst_held@%0d: got %b want %b", j, btn_held, exp5); end
    end
    n_cmp++; if (dir_req !== 4'b0100) begin n_err++; $display("FAIL midrst_after_req: got %b want 0100", dir_req); end
    n_cmp++; if (dir_valid !== 1'b1) begin n_err++; $display("FAIL midrst_after_valid: got %b want 1", dir_valid); end
    settle();
  endtask

`ifdef BTN_PAUSE_EN
  task automatic test_pause();
    ack_pulse();
    btn_c = 1'b1;
    repeat (7) tick();
    n_cmp++; if (btn_press !== 5'b10000) begin n_err++; $display("FAIL pause_c_press: got %b want 10000", btn_press); end
    tick();
    n_cmp++; if (paused !== 1'b1) begin n_err++; $display("FAIL pause_on: got %b want 1", paused); end
    settle();
    btn_u = 1'b1;
    repeat (7) tick();
    n_cmp++; if (btn_press !== 5'b01000) begin n_err++; $display("FAIL pause_u_press: got %b want 01000", btn_press); end
    tick();
    n_cmp++; if (dir_valid !== 1'b0) begin n_err++; $display("FAIL pause_valid: got %b want 0", dir_valid); end
    n_cmp++; if (dir_req !== 4'b0100) begin n_err++; $display("FAIL pause_dir_req: got %b want 0100", dir_req); end
    settle();
    btn_c = 1'b1;
    repeat (8) tick();
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL pause_off: got %b want 0", paused); end
    settle();
  endtask
`else
  task automatic test_centre();
    ack_pulse();
    btn_c = 1'b1;
    repeat (7) tick();
    n_cmp++; if (btn_press !== 5'b10000) begin n_err++; $display("FAIL centre_press: got %b want 10000", btn_press); end
    tick();
    n_cmp++; if (btn_held !== 5'b10000) begin n_err++; $display("FAIL centre_held: got %b want 10000", btn_held); end
    n_cmp++; if (dir_valid !== 1'b0) begin n_err++; $display("FAIL centre_valid: got %b want 0", dir_valid); end
    n_cmp++; if (dir_req !== 4'b0100) begin n_err++; $display("FAIL centre_dir_req: got %b want 0100", dir_req); end
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL centre_paused: got %b want 0", paused); end
    settle();
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_ack_collision();
    test_reset_mid();
`ifdef BTN_PAUSE_EN
    test_pause();
`else
    test_centre();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_input_ctrl.md
# btn_input_ctrl

Front-end input stage between the board push-buttons and the game logic. It synchronises and debounces the five buttons (up, down, left, right, centre). It converts direction presses into a latched one-hot direction request with a valid/ack handshake, and optionally derives a pause toggle from the centre button. It runs on the board clock and replaces the raw `btn_*` wiring into the game-logic block.

## Interface
- `DEB_CYCLES`, default 1_000_000: stable cycles required to accept a level change (10 ms at 100 MHz); legal range 2..2^CNT_W.
- `CNT_W`, default 20: debounce counter width.
- `clk` in 1: board clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `btn_u, btn_d, btn_l, btn_r, btn_c` in 1 each: raw asynchronous buttons, active-high.
- `dir_ack` in 1: single-cycle pulse from the consumer; clears `dir_valid`.
- `dir_req` out 4: one-hot direction: RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000; 0000 until the first press.
- `dir_valid` out 1: high while an unconsumed request is held.
- `btn_held` out 5: debounced levels {c,u,d,l,r}.
- `btn_press` out 5: one-cycle pulse on each debounced press, same bit order.
- `paused` out 1: pause state.

## Operation
- Each button passes through a 2-FF synchroniser (reset 0), then a debounce FSM with states IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
  - IDLE: on sync=1, go to CONFIRM_PRESS with the counter cleared.
  - CONFIRM_PRESS: on sync=0, return to IDLE (bounce; no event). When sync=1 and cnt==DEB_CYCLES-1, go to HELD and pulse press; otherwise increment cnt.
  - HELD: on sync=0, go to CONFIRM_RELEASE with the counter cleared.
  - CONFIRM_RELEASE: mirrors CONFIRM_PRESS. Return to HELD on sync=1; reach IDLE after DEB_CYCLES stable-low cycles. No release pulse.
- `btn_held[i]` is 1 in HELD and CONFIRM_RELEASE.
- Direction latch:
  - Any direction press loads `dir_req` and sets `dir_valid`.
  - Simultaneous direction presses resolve by priority U > D > L > R.
  - A new press while valid overwrites `dir_req`; there is no queue.
  - `dir_ack` clears `dir_valid`; `dir_req` keeps its value.
  - If `dir_ack` and a press land in the same cycle, the press wins: new direction loaded, `dir_valid`=1.
  - `dir_ack` while not valid is ignored.
- The centre button never affects `dir_req`.
- Reset values: synchronisers 0, FSMs IDLE, counters 0, `dir_req`=0000, `dir_valid`=0, `btn_held`=0, `btn_press`=0, `paused`=0.
- Reset mid-debounce aborts the pending event with no pulse. A button held through reset release must complete a full confirm before it is seen.

## Timing
- Raw button rises before edge k:
  - sync high after edge k+1;
  - FSM enters CONFIRM_PRESS at edge k+2;
  - `btn_press` and `btn_held` assert after edge k+2+DEB_CYCLES;
  - `dir_req`/`dir_valid` update after edge k+3+DEB_CYCLES.
- `btn_press` is exactly one cycle wide. A button held indefinitely produces no repeat.
- `dir_ack` takes effect at the edge where it is sampled; `dir_valid` is low the next cycle.
- The counter never exceeds DEB_CYCLES-1, so there is no wrap-around.

## Configuration
- `BTN_PAUSE_EN` defined: each centre press toggles `paused`. While `paused`=1, direction presses still update `btn_held`/`btn_press` but do not load `dir_req` or set `dir_valid`. `dir_ack` still clears valid.
- `BTN_PAUSE_EN` undefined: `paused` tied 0 and the toggle register is removed. The centre button appears only in `btn_held[4]`/`btn_press[4]`.

## Structure
- Shared package holds:
  - direction constants DIR_RIGHT/DIR_LEFT/DIR_UP/DIR_DOWN, matching the game-logic encoding;
  - debounce state typedef/encoding;
  - button bit-index constants.
- Sub-module `btn_debounce` (synchroniser, FSM, counter, press pulse) is instantiated five times. The top level holds the priority encoder, direction latch/handshake and pause toggle.

## Test plan
All scenarios use DEB_CYCLES=4.
- Clean press: `btn_u` high before edge 0 → `btn_press[3]` pulses after edge 6; `dir_req`=0010 and `dir_valid`=1 after edge 7.
- Bounce: `btn_r` high 2 cycles, low 1 cycle, then high → no pulse until 4 stable cycles after the final rise; exactly one pulse; `dir_req`=0001.
- Simultaneous `btn_l` and `btn_d` rising on the same edge → `dir_req`=0100.
- Ack/press collision: valid LEFT held; `dir_ack` coincides with a new RIGHT press pulse → `dir_req`=0001, `dir_valid` stays 1. A following lone `dir_ack` → `dir_valid`=0, `dir_req` stays 0001.
- Reset mid-confirm: `rst`=0 for one cycle while `btn_d` is in CONFIRM_PRESS, `btn_d` held high → all outputs reset; pulse arrives 6 cycles after `rst` returns high.
- With `BTN_PAUSE_EN`: `btn_c` press → `paused`=1. `btn_u` press → `btn_press[3]` pulses, `dir_valid` stays 0. Second `btn_c` press → `paused`=0.
